// File: rtl/vga_pkg.sv
// vga_pkg: shared axis state encoding and default 640x480@60 timing constants.
package vga_pkg;
    typedef enum logic [1:0] {AX_ACT, AX_FP, AX_SYNC, AX_BP} axis_state_t;
    localparam int COORD_W      = 10;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
endpackage

// File: rtl/vga_axis_fsm.sv
// vga_axis_fsm: one raster axis; counts 0..TOTAL-1 per step, tracks ACT/FP/SYNC/BP, flags the wrap step.
module vga_axis_fsm import vga_pkg::*; #(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output axis_state_t        state,
    output logic               wrap
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] B_FP   = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] B_SYNC = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] B_BP   = COORD_W'(ACTIVE + FP + SYNC);
    logic [COORD_W-1:0] count_nxt;
    axis_state_t state_nxt;
    // State is decoded from the count being loaded so both registers stay in lockstep.
    always_comb begin
        wrap      = step && count == LAST;
        count_nxt = !step ? count : wrap ? '0 : count + 1'b1;
        state_nxt = count_nxt < B_FP ? AX_ACT : count_nxt < B_SYNC ? AX_FP :
                    count_nxt < B_BP ? AX_SYNC : AX_BP;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count <= LAST;
            state <= AX_BP;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
        end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (pixel strobe, x/y, syncs, blank); VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
module vga_timing_gen import vga_pkg::*; #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_en,
    output logic               vga_clk,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               h_sync,
    output logic               v_sync,
    output logic               blank_n,
    output logic               line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic               frame_start,
    output logic [15:0]        frame_cnt
`else
    output logic               frame_start
`endif
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic POL = 1'(SYNC_POL);
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic h_wrap, v_wrap;
    axis_state_t h_state, v_state;
    assign div_nxt = div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
    vga_axis_fsm #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(clk), .rst_n(rst_n), .step(pix_en), .count(x), .state(h_state), .wrap(h_wrap));
    vga_axis_fsm #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(clk), .rst_n(rst_n), .step(h_wrap), .count(y), .state(v_state), .wrap(v_wrap));
    assign h_sync  = h_state == AX_SYNC ? POL : ~POL;
    assign v_sync  = v_state == AX_SYNC ? POL : ~POL;
    assign blank_n = h_state == AX_ACT && v_state == AX_ACT;
    // vga_clk rises on the pixel-advance edge; with CLK_DIV=1 it degenerates to pix_en.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            vga_clk     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            pix_en      <= div_nxt == DIV_LAST;
            vga_clk     <= CLK_DIV == 1 || div_nxt < DIV_HALF;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) frame_cnt <= '0;
        else if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 1'b1;
`else
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of the VGA paint stage.
- Divides the system clock into a pixel strobe and runs horizontal and vertical counters/state machines.
- Produces the X/Y coordinates (10-bit, raw counter values including blanking) consumed by the paint stage, plus h_sync, v_sync, blank_n and a pixel clock for the DAC.
- Default parameters give 640x480@60 Hz from a 50 MHz clk.

Parameters:
- CLK_DIV, 2: clk cycles per pixel; legal range >=1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BP, 33: vertical back porch, lines.
- SYNC_POL, 0: sync asserted level (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_en  out  1  one-clk strobe; the pixel advances on this edge.
- vga_clk  out  1  pixel clock to DAC; high for the first half of each pixel period. When CLK_DIV=1, vga_clk = ~clk-phase is not generated; it is tied to pix_en.
- x  out  10  horizontal counter, 0..H_TOTAL-1.
- y  out  10  vertical counter, 0..V_TOTAL-1.
- h_sync  out  1  horizontal sync at SYNC_POL when asserted.
- v_sync  out  1  vertical sync at SYNC_POL when asserted.
- blank_n  out  1  high only inside the visible area.
- line_start  out  1  one-clk pulse when x becomes 0.
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0).

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Both must be <=1024.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered high for the one clk cycle in which div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Counter advance: on every clk edge where pix_en=1:
  - x increments; at x=H_TOTAL-1 it wraps to 0 and y advances.
  - y wraps from V_TOTAL-1 to 0.
- Per-axis FSM, states ACT -> FP -> SYNC -> BP -> ACT:
  - Each state lasts its parameter count.
  - Horizontal FSM steps on pix_en. Vertical FSM steps only on the horizontal wrap.
- Registered outputs: x, y, h_sync, v_sync, blank_n all update on the same edge and are mutually consistent for the same pixel (zero skew between them).
  - h_sync is asserted iff horizontal state = SYNC (default x = 656..751).
  - v_sync is asserted iff vertical state = SYNC (default y = 490..491).
  - blank_n = (h state = ACT) && (v state = ACT).
- line_start / frame_start: high for exactly one clk cycle (not CLK_DIV cycles), in the cycle after the edge that loads x=0 / (0,0).
- Reset values (asynchronous):
  - div_cnt=0, pix_en=0, vga_clk=0.
  - x=H_TOTAL-1, y=V_TOTAL-1; both FSMs in BP.
  - h_sync = v_sync = ~SYNC_POL; blank_n=0.
  - line_start = frame_start = 0.
  - The first pix_en edge after reset release wraps to (0,0) and pulses frame_start and line_start together.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no partial sync pulse held.
- Last pixel (H_TOTAL-1, V_TOTAL-1): x and y wrap on the same edge, and both pulses fire in the same cycle.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output port frame_cnt [15:0].
  - Reset 0; increments on the same cycle frame_start is high; wraps 65535->0.
  - Consumers use it for frame-paced animation.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Package vga_pkg:
  - enum axis_state_t {AX_ACT, AX_FP, AX_SYNC, AX_BP}.
  - Default 640x480 timing constants.
  - COORD_W=10.
- Sub-module vga_axis_fsm:
  - Parameterised by ACTIVE/FP/SYNC/BP.
  - Inputs: step, clk, rst_n.
  - Outputs: count, state, wrap.
  - Instantiated once for horizontal and once for vertical; the horizontal wrap drives the vertical step.

Test Plan:
- Reset release, defaults -> first pix_en at clk edge 2; frame_start and line_start pulse once; x=0, y=0, blank_n=1.
- One full line -> line_start period = 1600 clk. h_sync low for 192 clk starting at x=656. blank_n high for x=0..639 only.
- One full frame -> frame_start period = 840000 clk. v_sync low during y=490..491. Exactly 307200 pix_en strobes with blank_n=1.
- Assert rst_n low at x=700, y=491 (inside both syncs) -> h_sync=v_sync=1, blank_n=0, x=799, y=524 asynchronously, before the next clk edge.
- CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> pix_en constant 1; line period 14 clk; frame period 98 clk; h_sync at x=10..11.
- With VGA_TIMING_FRAME_CNT_EN, run 3 frames -> frame_cnt reads 1, 2, 3 on successive frame_start cycles.
